// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle (LSB first) through a single 4-bit adder.
// Latency NIB cycles from accept to out_valid; no input/output overlap; result held until out_ready.

module four_bit_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [4:0] w_total;

  assign w_total = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
  assign s       = w_total[3:0];
  assign c_out   = w_total[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_x;
  logic [3:0]       w_y;
  logic [3:0]       w_s;
  logic             w_co;
  logic             w_last;
  logic             w_ovf;

  assign w_x    = r_a[4*r_idx +: 4];
  assign w_y    = r_b[4*r_idx +: 4];
  assign w_last = (r_idx == IW'(NIB - 1));

  four_bit_adder u_add (
    .x     (w_x),
    .y     (w_y),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_co)
  );

  // Overflow: operands share a sign and the final sum MSB (from the last nibble step) differs.
  assign w_ovf = (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_s[3]);

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[4*r_idx +: 4] <= w_s;
          r_carry             <= w_co;
          // idx parks on the last nibble rather than wrapping.
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_ovf;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed table, backpressure/reset sequences,
// and random back-to-back runs at WIDTH=16 and WIDTH=32 against a scoreboard.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst;
  logic        iv16, ir16, cin16, ov16, or16, co16, of16, bz16;
  logic [15:0] a16, b16, s16;
  logic        iv32, ir32, cin32, ov32, or32, co32, of32, bz32;
  logic [31:0] a32, b32, s32;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16), .busy(bz16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32), .busy(bz32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: {ovf, cout, sum} from a full-width add.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] t;
    logic [31:0] s;
    logic        co, ov;
    if (w == 16) begin
      t  = {17'd0, x[15:0]} + {17'd0, y[15:0]} + {32'd0, c};
      s  = {16'd0, t[15:0]};
      co = t[16];
      ov = (x[15] == y[15]) && (s[15] != x[15]);
    end else begin
      t  = {1'b0, x} + {1'b0, y} + {32'd0, c};
      s  = t[31:0];
      co = t[32];
      ov = (x[31] == y[31]) && (s[31] != x[31]);
    end
    return {ov, co, s};
  endfunction

  logic [33:0] q16[$];
  logic [33:0] q32[$];
  bit          sp16 = 0, sp32 = 0;
  int          last16 = -1, last32 = -1;

  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      q16.delete();
    end else begin
      if (iv16 && ir16) begin
        q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16));
        if (sp16 && last16 >= 0) chk("spacing16", 64'(cyc - last16), 64'd6);
        last16 = cyc;
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) chk("sb16_spurious", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          chk("sb16_sum", {48'd0, s16}, {48'd0, e[15:0]});
          chk("sb16_cout_ovf", {62'd0, co16, of16}, {62'd0, e[32], e[33]});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      q32.delete();
    end else begin
      if (iv32 && ir32) begin
        q32.push_back(model(32, a32, b32, cin32));
        if (sp32 && last32 >= 0) chk("spacing32", 64'(cyc - last32), 64'd10);
        last32 = cyc;
      end
      if (ov32 && or32) begin
        if (q32.size() == 0) chk("sb32_spurious", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          chk("sb32_sum", {32'd0, s32}, {32'd0, e[31:0]});
          chk("sb32_cout_ovf", {62'd0, co32, of32}, {62'd0, e[32], e[33]});
        end
      end
    end
  end

  task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic c);
    int k;
    a16 = x; b16 = y; cin16 = c; iv16 = 1'b1;
    k = 0;
    while (!ir16 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic finish16(input string nm, input logic [15:0] es, input logic eco, input logic eov,
                          input bit chk_lat);
    int n;
    n = 0;
    while (!ov16 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (chk_lat) chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_sum"}, {48'd0, s16}, {48'd0, es});
    chk({nm, "_cout"}, {63'd0, co16}, {63'd0, eco});
    chk({nm, "_ovf"}, {63'd0, of16}, {63'd0, eov});
    or16 = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; or16 = 1;
    iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; or32 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, ir16}, 64'd0);
    chk("rst_out_valid", {63'd0, ov16}, 64'd0);
    chk("rst_sum", {48'd0, s16}, 64'd0);
    chk("rst_cout_ovf_busy", {61'd0, co16, of16, bz16}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {63'd0, ir16}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      start16(tbl[i].a, tbl[i].b, tbl[i].cin);
      finish16($sformatf("vec%0d", i), tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1);
    end

    // Backpressure: result held while out_ready low, new operands wait.
    or16 = 1'b0;
    start16(16'h1111, 16'h2222, 1'b0);
    k = 0;
    while (!ov16 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    a16 = 16'h0101; b16 = 16'h0202; cin16 = 1'b0; iv16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {63'd0, ov16}, 64'd1);
      chk("bp_in_ready", {63'd0, ir16}, 64'd0);
      chk("bp_hold_sum", {48'd0, s16}, 64'h3333);
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {63'd0, ov16}, 64'd0);
    chk("bp_release_ready", {63'd0, ir16}, 64'd1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    chk("bp_new_taken", {62'd0, bz16, ir16}, 64'b10);
    finish16("bp_next", 16'h0303, 1'b0, 1'b0, 1'b0);

    // Reset during the second RUN cycle discards the operation.
    start16(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {63'd0, bz16}, 64'd0);
    chk("midrst_valid", {63'd0, ov16}, 64'd0);
    chk("midrst_sum", {48'd0, s16}, 64'd0);
    chk("midrst_ready_low", {63'd0, ir16}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_spurious", {63'd0, ov16}, 64'd0);
    end
    start16(16'h0F0F, 16'hF0F1, 1'b0);
    finish16("after_rst", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Random back-to-back, WIDTH=16.
    or16 = 1'b1; last16 = -1; sp16 = 1;
    for (int i = 0; i < 200; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
      iv16 = 1'b1;
      k = 0;
      while (!ir16 && k < 100) begin
        @(posedge clk); #1; k++;
      end
      if (k >= 100) chk("rand16_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    iv16 = 1'b0; sp16 = 0;
    k = 0;
    while (q16.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("rand16_drain", 64'(q16.size()), 64'd0);

    // Random back-to-back, WIDTH=32.
    or32 = 1'b1; last32 = -1; sp32 = 1;
    for (int i = 0; i < 200; i++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1));
      iv32 = 1'b1;
      k = 0;
      while (!ir32 && k < 100) begin
        @(posedge clk); #1; k++;
      end
      if (k >= 100) chk("rand32_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    iv32 = 1'b0; sp32 = 0;
    k = 0;
    while (q32.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("rand32_drain", 64'(q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
